// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle restoring divider sequencer for DIV/DIVU in EX
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [63:0] work, work_n;
    logic [31:0] divisor, divisor_n;
    logic        neg_quo, neg_quo_n;
    logic        neg_rem, neg_rem_n;
    logic [63:0] result_n;
    logic        ready_n;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [63:0] work_step;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] dividend_abs, divisor_abs;

    // work holds {partial remainder, remaining dividend bits / quotient bits}
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            work     <= 64'd0;
            divisor  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work     <= work_n;
            divisor  <= divisor_n;
            neg_quo  <= neg_quo_n;
            neg_rem  <= neg_rem_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        work_n     = work;
        divisor_n  = divisor;
        neg_quo_n  = neg_quo;
        neg_rem_n  = neg_rem;
        result_n   = result_o;
        ready_n    = ready_o;
        stallreq_o = 1'b0;

        dividend_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        divisor_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

        // remainder is always below the divisor, so the 33rd bit only carries the borrow
        shifted   = {work, 1'b0};
        diff      = shifted[64:32] - {1'b0, divisor};
        work_step = diff[32] ? shifted[63:0] : {diff[31:0], shifted[31:1], 1'b1};
        quo_fix   = neg_quo ? (~work_step[31:0] + 32'd1) : work_step[31:0];
        rem_fix   = neg_rem ? (~work_step[63:32] + 32'd1) : work_step[63:32];

        case (state)
            FREE: begin
                ready_n  = 1'b0;
                result_n = 64'd0;
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    work_n     = {32'd0, dividend_abs};
                    divisor_n  = divisor_abs;
                    neg_quo_n  = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_n  = signed_div_i && opdata1_i[31];
                    cnt_n      = 6'd0;
                    state_n    = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_n = FREE;
                end else begin
                    stallreq_o = 1'b1;
                    result_n   = 64'd0;
                    ready_n    = 1'b1;
                    state_n    = END;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_n = FREE;
                end else begin
                    stallreq_o = 1'b1;
                    work_n     = work_step;
                    cnt_n      = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        result_n = {rem_fix, quo_fix};
                        ready_n  = 1'b1;
                        state_n  = END;
                    end
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    ready_n  = 1'b0;
                    result_n = 64'd0;
                    state_n  = FREE;
                end
            end
            default: state_n = FREE;
        endcase
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against a transaction-level model
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, stallreq;

    int n_vec = 0;
    int n_bad = 0;

    div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (opdata1),
        .opdata2_i   (opdata2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready),
        .stallreq_o  (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // model: cycles remaining until the result appears, then a done phase held by start
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_res  = 64'd0;
    bit          run    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 64'd0;
        end else if (m_done) begin
            if (annul || !start) m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (annul) m_left <= 0;
            else if (m_left == 1) begin
                m_left <= 0;
                m_done <= 1'b1;
            end else m_left <= m_left - 1;
        end else if (start && !annul) begin
            m_left <= (opdata2 == 32'd0) ? 1 : 32;
            m_res  <= ref_div(signed_div, opdata1, opdata2);
        end
    end

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("mdl ready", 64'(ready), 64'(m_done));
            chk("mdl result", result, m_done ? m_res : 64'd0);
            chk("mdl stallreq", 64'(stallreq),
                64'(!annul && (m_left > 0 || (!m_done && start))));
        end
    end

    task automatic wait_ready(output int lat);
        lat = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
            if (ready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_op(input string name, input logic [63:0] exp, input int exp_lat, input int lat);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, result, exp);
        start = 1'b0;
        @(negedge clk);
        chk({name, " ready after drop"}, 64'(ready), 64'd0);
        chk({name, " result after drop"}, result, 64'd0);
    endtask

    task automatic run_op(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        @(posedge clk);
        #1;
        signed_div = s;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        #1;
        chk({name, " stall c0"}, 64'(stallreq), 64'd1);
        wait_ready(lat);
        chk({name, " stall at ready"}, 64'(stallreq), 64'd0);
        finish_op(name, exp, exp_lat, lat);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;

        chk("pin divu 100/7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        chk("pin div -7/2", ref_div(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        chk("pin div 7/-2", ref_div(1'b1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
        chk("pin div ovf", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset stallreq", 64'(stallreq), 64'd0);
        run = 1'b1;

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        run_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        run_op("divu 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        run_op("div -100/0", 1'b1, 32'hFFFFFF9C, 32'd0, 64'd0, 2);
        run_op("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_op("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
        run_op("divu 7/9", 1'b0, 32'd7, 32'd9, 64'h00000007_00000000, 33);
        run_op("div -9/-4", 1'b1, 32'hFFFFFFF7, 32'hFFFFFFFC, 64'hFFFFFFFF_00000002, 33);

        // annul pulsed in c10, new request taken in c11
        @(posedge clk);
        #1 signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1; opdata1 = 32'd9; opdata2 = 32'd3;
        @(posedge clk);
        #1 annul = 1'b0;
        #1 chk("annul c11 stall", 64'(stallreq), 64'd1);
        wait_ready(lat);
        finish_op("annul then divu 9/3", 64'h00000000_00000003, 33, lat);

        // reset in c20 of an operation, start still held
        @(posedge clk);
        #1 signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        opdata1 = 32'd50; opdata2 = 32'd5;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst ready", 64'(ready), 64'd0);
        chk("rst result", result, 64'd0);
        chk("rst stallreq", 64'(stallreq), 64'd1);
        wait_ready(lat);
        finish_op("after rst divu 50/5", 64'h00000000_0000000A, 32, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle divider sequencer for the EX stage. Accepts a DIV/DIVU request from EX and runs a 32-iteration restoring shift-subtract division. It raises a stall request while busy and returns a 64-bit {remainder, quotient} result for the HI/LO write path. EX holds the request until the result is ready; the pipeline controller uses the stall request to freeze earlier stages.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by EX until ready_o is seen
- annul_i  in  1  cancel (flush/exception); aborts any operation in progress
- result_o  out  64  registered result; [63:32] remainder (to HI), [31:0] quotient (to LO)
- ready_o  out  1  registered; result_o valid
- stallreq_o  out  1  combinational; pipeline must stall

## Operation
- States: FREE, BYZERO, ON, END. A 6-bit iteration counter cnt is used in ON.
- FREE:
  - start_i=1 and annul_i=0: latch operands and sign mode. Go to BYZERO if divisor==0, else ON with cnt=0.
  - Otherwise stay; ready_o=0, result_o=0.
- Signed mode: latch |dividend| and |divisor| (two's-complement negate when bit31=1). Record quotient sign = dividend[31]^divisor[31] and remainder sign = dividend[31].
- ON, one iteration per cycle:
  - Shift the 65-bit working register {partial remainder, dividend bits} left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; else restore and set the LSB to 0.
  - cnt increments. After the iteration with cnt==31, go to END.
  - annul_i=1 in ON: go to FREE, discard the work.
- Sign fix-up on entry to END (signed mode only): negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1.
- Unsigned mode uses raw operands and applies no fix-up.
- BYZERO: load result 0, go to END next cycle. annul_i=1 goes to FREE.
- END:
  - ready_o=1 and result_o holds the result for as long as start_i=1.
  - start_i=0: go to FREE; ready_o=0 and result_o=0 next cycle.
  - annul_i=1: go to FREE.
- Operand input changes after acceptance are ignored.
- Overflow case 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. It wraps; no trap.
- stallreq_o = 1 in either case below, 0 otherwise (including END):
  - state FREE and start_i=1 and annul_i=0
  - state ON or BYZERO and annul_i=0
- Reset: state FREE, cnt=0, ready_o=0, result_o=0. rst has priority over all inputs in every state.

## Timing
- c0 = cycle in FREE with start_i=1 and annul_i=0.
- Normal path: ON occupies c1..c32; END in c33 with ready_o=1. Latency is 33 cycles.
- Divide-by-zero: BYZERO in c1, END in c2.
- Back-to-back operations: from END with start_i dropped, FREE follows one cycle later. A new start is accepted in that FREE cycle at the earliest.
- annul_i sampled in cycle cK (K≥1) puts the block in FREE in cK+1; ready_o never rises for that operation.
- annul_i and start_i both high in FREE: the request is not accepted.

## Test plan
- DIVU 100 / 7, start at c0: ready_o=1 in c33 → result_o=0x00000002_0000000E; stallreq_o=1 in c0..c32, 0 in c33.
- DIV 0xFFFFFFF9 (-7) / 2 → result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). DIV 7 / -2 → 0x00000001_FFFFFFFD.
- DIVU 5 / 0 → ready_o=1 in c2, result_o=0. Then drop start_i → ready_o=0 and result_o=0 in the next cycle.
- Signed 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000. DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- annul_i pulsed in c10 → FREE in c11, ready_o stays 0. New start (DIVU 9/3) in c11 → result_o=0x00000000_00000003 with ready_o=1 in c44.
- rst asserted in c20 of an operation → next cycle: FREE, ready_o=0, result_o=0, stallreq_o follows start_i.
